fixed_point_dot_mac: RTL and testbench
======================================

# fixed_point_dot_mac

Parametrised, pipelined fixed-point dot-product multiply-accumulate for the MobileNetV3 accelerator; the multi-lane successor of the single fixed-point multiplier. Each accepted beat multiplies LANES signed operand pairs, rounds every product back to the data Q-format, sums across lanes and accumulates over a variable-length group delimited by a last flag. The block emits one saturated result per group. It sits between the line buffers and the output/activation stage, feeding convolution partial sums.

## Interface
- bitsize, 14: width of each signed operand; Q(bitsize-FRAC_BITS).FRAC_BITS
- FRAC_BITS, 9: fractional bits of operands and result
- LANES, 4: operand pairs per beat (power of two, ≥1)
- GUARD_BITS, 6: extra accumulator headroom bits
- Derived: OUT_BITS = 2*bitsize-FRAC_BITS; ACC_BITS = OUT_BITS+GUARD_BITS

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_flag  in  1  beat valid; a/b/last_flag sampled when high
- last_flag  in  1  final beat of the current group (ignored when start_flag low)
- a  in  LANES*bitsize  packed signed operands, lane i at [i*bitsize +: bitsize]
- b  in  LANES*bitsize  packed signed weights, same packing
- Mul_result  out  OUT_BITS  signed saturated group result
- valid  out  1  one-cycle pulse, Mul_result/sat valid
- sat  out  1  result was clamped (qualified by valid)

## Operation
- Stage P (edge k): per lane, full 2*bitsize-bit signed product registered; valid/last/first tags registered alongside.
- Stage S (edge k+1): each product rounded half-up: (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS, giving an OUT_BITS-bit value; lanes summed in OUT_BITS+log2(LANES) bits, sign-extended, registered.
- Stage A (edge k+2): if beat is first of group, acc <= sum; else acc <= acc + sum. ACC_BITS wide, two's complement; wraps silently if beats*LANES > 2^GUARD_BITS (caller's responsibility).
- Stage O (edge k+3): on a last beat, Mul_result <= clamp(acc) to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]; sat <= 1 if clamped; valid <= 1. Otherwise valid <= 0, Mul_result and sat hold.
- first tag: set on the first accepted beat after reset or after any accepted last beat.
- Bubbles (start_flag low) propagate as invalid tags; acc unchanged.
- Single-beat group (start_flag & last_flag on first beat): result = clamp(sum).

## Timing
- Reset: all pipeline registers, acc, Mul_result, sat, valid = 0; first flag = 1. Takes effect immediately (asynchronous); partial group discarded.
- Latency: valid high in the cycle following edge k+3, where edge k samples the last beat.
- Throughput: one beat per cycle, no stall. Back-to-back groups supported: new group's first beat reloads acc at the same edge the previous result is registered from the old acc; no cycle lost.
- valid never high for two consecutive cycles unless two consecutive accepted beats both carry last_flag.
- No ready/back-pressure; downstream must accept every valid pulse.

## Test plan
- Rounding, single beat: lane0 a=104 (0b00000_001101000), b=-12, others 0, start_flag=last_flag=1 -> 3 cycles later valid=1, Mul_result=-2 (19'h7FFFE), sat=0.
- Tie rounding: lane0 a=1,b=256 -> 1; separate group lane0 a=1,b=-256 -> 0.
- Multi-beat: 3 beats, all lanes a=b=512 (1.0), last on beat 3 -> single valid pulse, Mul_result=6144, no valid on beats 1–2.
- Saturation: all lanes a=b=8191, single beat -> Mul_result=262143, sat=1; all lanes a=-8192,b=8191 -> Mul_result=-262144, sat=1.
- Bubbles and back-to-back: 2-beat group with a one-cycle gap, immediately followed by a 1-beat group -> two valid pulses, correct independent sums, second group unaffected by first acc.
- Reset mid-group: assert rst after beat 2 of 4, release, send a fresh 1-beat group -> outputs 0 during reset, no stale valid, result equals the new group only.

Source files
------------

// File: rtl/fixed_point_dot_mac_if.sv
// fixed_point_dot_mac_if: beat input / group result bus of the fixed-point dot-product MAC
interface fixed_point_dot_mac_if #(
    parameter int bitsize   = 14,
    parameter int FRAC_BITS = 9,
    parameter int LANES     = 4
);
    localparam int OUT_BITS = 2*bitsize - FRAC_BITS;
    logic                     start_flag;
    logic                     last_flag;
    logic [LANES*bitsize-1:0] a;
    logic [LANES*bitsize-1:0] b;
    logic [OUT_BITS-1:0]      Mul_result;
    logic                     valid;
    logic                     sat;
    modport master(output start_flag, last_flag, a, b, input Mul_result, valid, sat);
    modport slave(input start_flag, last_flag, a, b, output Mul_result, valid, sat);
endinterface

// File: rtl/fixed_point_dot_mac.sv
// fixed_point_dot_mac: pipelined multi-lane fixed-point dot product, accumulated per
// last-delimited group and emitted as one saturated result.
module fixed_point_dot_mac #(
    parameter int bitsize    = 14,
    parameter int FRAC_BITS  = 9,
    parameter int LANES      = 4,
    parameter int GUARD_BITS = 6
) (
    input logic                  clk,
    input logic                  rst,
    fixed_point_dot_mac_if.slave bus
);
    localparam int OUT_BITS  = 2*bitsize - FRAC_BITS;
    localparam int ACC_BITS  = OUT_BITS + GUARD_BITS;
    localparam int PROD_BITS = 2*bitsize;
    localparam int SUM_BITS  = OUT_BITS + $clog2(LANES);
    localparam logic signed [PROD_BITS-1:0] HALF = PROD_BITS'(1) << (FRAC_BITS-1);

    logic signed [PROD_BITS-1:0] w_prod [LANES];
    logic signed [PROD_BITS-1:0] r_prod [LANES];
    logic signed [SUM_BITS-1:0]  w_sum;
    logic signed [ACC_BITS-1:0]  r_sum, r_acc;
    logic [OUT_BITS-1:0]         w_clamp, r_result;
    logic                        w_ovf, r_sat, r_valid, r_first;
    logic                        r_p_valid, r_p_last, r_p_first;
    logic                        r_s_valid, r_s_last, r_s_first, r_a_last;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = PROD_BITS'($signed(bus.a[i*bitsize +: bitsize])) *
                        PROD_BITS'($signed(bus.b[i*bitsize +: bitsize]));
            w_sum = w_sum + SUM_BITS'((r_prod[i] + HALF) >>> FRAC_BITS);
        end
    end

    // accumulator fits the output range only when its top GUARD_BITS+1 bits agree
    assign w_ovf   = ~(&r_acc[ACC_BITS-1:OUT_BITS-1]) & (|r_acc[ACC_BITS-1:OUT_BITS-1]);
    assign w_clamp = w_ovf ? {r_acc[ACC_BITS-1], {(OUT_BITS-1){~r_acc[ACC_BITS-1]}}}
                           : r_acc[OUT_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod    <= '{default: '0};
            r_first   <= 1'b1;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_first <= 1'b0;
            r_sum     <= '0;
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_s_first <= 1'b0;
            r_acc     <= '0;
            r_a_last  <= 1'b0;
            r_result  <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (bus.start_flag) r_first <= bus.last_flag;
            r_prod    <= w_prod;
            r_p_valid <= bus.start_flag;
            r_p_last  <= bus.start_flag & bus.last_flag;
            r_p_first <= r_first;
            r_sum     <= ACC_BITS'(w_sum);
            r_s_valid <= r_p_valid;
            r_s_last  <= r_p_last;
            r_s_first <= r_p_first;
            if (r_s_valid) r_acc <= r_s_first ? r_sum : r_acc + r_sum;
            r_a_last  <= r_s_valid & r_s_last;
            r_valid   <= r_a_last;
            if (r_a_last) begin
                r_result <= w_clamp;
                r_sat    <= w_ovf;
            end
        end
    end

    assign bus.Mul_result = r_result;
    assign bus.sat        = r_sat;
    assign bus.valid      = r_valid;
endmodule

// File: tb/tb_fixed_point_dot_mac.sv
// tb_fixed_point_dot_mac: directed spec cases plus random groups against an arithmetic
// model of the group dot product with rounding, accumulation and clamping.
module tb_fixed_point_dot_mac;
    localparam int BS = 14, FB = 9, LN = 4, GB = 6, OB = 2*BS - FB;
    localparam longint MAXV = (longint'(1) << (OB-1)) - 1;
    localparam longint MINV = -(longint'(1) << (OB-1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_point_dot_mac_if #(.bitsize(BS), .FRAC_BITS(FB), .LANES(LN)) bus();
    fixed_point_dot_mac #(.bitsize(BS), .FRAC_BITS(FB), .LANES(LN), .GUARD_BITS(GB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit exp_v [0:4095];
    bit exp_s [0:4095];
    logic [OB-1:0] exp_r [0:4095];
    logic [OB-1:0] hold_r = '0;
    bit hold_s = 1'b0;
    longint m_acc = 0;
    bit m_first = 1'b1;
    int av [LN], bv [LN];
    int z [LN] = '{default: 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint lane_sum(input int x [LN], input int y [LN]);
        longint s = 0;
        for (int i = 0; i < LN; i++)
            s += (longint'(x[i]) * longint'(y[i]) + (longint'(1) << (FB-1))) >>> FB;
        return s;
    endfunction

    task automatic step(input bit v, input bit l, input int x [LN], input int y [LN]);
        longint s;
        @(negedge clk);
        bus.start_flag = v;
        bus.last_flag  = l;
        for (int i = 0; i < LN; i++) begin
            bus.a[i*BS +: BS] = x[i][BS-1:0];
            bus.b[i*BS +: BS] = y[i][BS-1:0];
        end
        @(posedge clk);
        cyc++;
        if (v) begin
            s = lane_sum(x, y);
            m_acc = m_first ? s : m_acc + s;
            m_first = l;
            if (l) begin
                exp_v[cyc+3] = 1'b1;
                exp_s[cyc+3] = (m_acc > MAXV) || (m_acc < MINV);
                exp_r[cyc+3] = OB'(m_acc > MAXV ? MAXV : (m_acc < MINV ? MINV : m_acc));
            end
        end
        #1;
        chk("valid", 32'(bus.valid), 32'(exp_v[cyc]));
        if (exp_v[cyc]) begin
            hold_r = exp_r[cyc];
            hold_s = exp_s[cyc];
        end
        chk("result", 32'(bus.Mul_result), 32'(hold_r));
        chk("sat", 32'(bus.sat), 32'(hold_s));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, z, z);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.start_flag = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.valid), 32'(0));
        chk("rst_result", 32'(bus.Mul_result), 32'(0));
        chk("rst_sat", 32'(bus.sat), 32'(0));
        @(posedge clk);
        cyc++;
        #1 chk("rst_hold", 32'(bus.valid), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = cyc; k < cyc + 6; k++) exp_v[k] = 1'b0;
        m_first = 1'b1;
        m_acc = 0;
        hold_r = '0;
        hold_s = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start_flag = 1'b0;
        bus.last_flag = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.valid), 32'(0));
        chk("reset_result", 32'(bus.Mul_result), 32'(0));
        chk("reset_sat", 32'(bus.sat), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        // rounding, single beat
        av = '{104, 0, 0, 0}; bv = '{-12, 0, 0, 0};
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_round", 32'(bus.Mul_result), 32'(19'h7FFFE));
        // tie rounding
        av = '{1, 0, 0, 0}; bv = '{256, 0, 0, 0};
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_tie_pos", 32'(bus.Mul_result), 32'(19'h00001));
        bv = '{-256, 0, 0, 0};
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_tie_neg", 32'(bus.Mul_result), 32'(19'h00000));
        // multi-beat
        av = '{512, 512, 512, 512}; bv = av;
        step(1'b1, 1'b0, av, bv); step(1'b1, 1'b0, av, bv); step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_multi", 32'(bus.Mul_result), 32'(19'h01800));
        // saturation both ways
        av = '{8191, 8191, 8191, 8191}; bv = av;
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_sat_pos", 32'(bus.Mul_result), 32'(19'h3FFFF));
        chk("tp_sat_pos_flag", 32'(bus.sat), 32'(1));
        av = '{-8192, -8192, -8192, -8192};
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_sat_neg", 32'(bus.Mul_result), 32'(19'h40000));
        chk("tp_sat_neg_flag", 32'(bus.sat), 32'(1));
        // bubble inside a group, then back-to-back single-beat group
        av = '{300, -700, 1000, 50}; bv = '{-900, 400, 2000, 8000};
        step(1'b1, 1'b0, av, bv);
        step(1'b0, 1'b1, bv, av);
        step(1'b1, 1'b1, bv, av);
        av = '{512, 0, 0, 0}; bv = '{1024, 0, 0, 0};
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_b2b_second", 32'(bus.Mul_result), 32'(19'h00400));
        // reset mid-group
        av = '{4000, 4000, 4000, 4000}; bv = av;
        step(1'b1, 1'b0, av, bv); step(1'b1, 1'b0, av, bv);
        do_reset();
        av = '{512, 0, 0, 0}; bv = av;
        step(1'b1, 1'b1, av, bv); idle(4);
        chk("tp_rst_new", 32'(bus.Mul_result), 32'(19'h00200));
        // random groups with bubbles and ignored inputs on bubbles
        for (int g = 0; g < 40; g++) begin
            int len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                for (int i = 0; i < LN; i++) begin
                    av[i] = int'($urandom_range(0, 16383)) - 8192;
                    bv[i] = int'($urandom_range(0, 16383)) - 8192;
                end
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), av, bv);
                step(1'b1, k == len - 1, av, bv);
            end
        end
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
